// File: rtl/ascon_serial_loader.sv
// Serial feeder for the bit-serial Ascon decryption core: captures parallel operands,
// shifts them MSB-first into the share inputs, pulses start, waits for ready.
// Optional 32-bit LFSR randomness enabled by `define ASCON_LOADER_LFSR_EN.
module ascon_serial_loader #(
    parameter int unsigned K         = 128,
    parameter int unsigned L         = 40,
    parameter int unsigned Y         = 80,
    parameter int unsigned START_CYC = 3,
    parameter logic [31:0] SEED      = 32'hACE1_2468
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [K-1:0]   key_in,
    input  logic [127:0]   nonce_in,
    input  logic [L-1:0]   ad_in,
    input  logic [Y-1:0]   ct_in,
    output logic [2:0]     keyxSO,
    output logic [2:0]     noncexSO,
    output logic [2:0]     associated_dataxSO,
    output logic [2:0]     cipher_textxSO,
    output logic [6:0]     r_64xSO,
    output logic           r_128xSO,
    output logic           r_ptxSO,
    output logic           decryption_startxSO,
    input  logic           decryption_readyxSI,
    output logic           busy,
    output logic           done
);

    localparam int unsigned M1  = (K > Y) ? K : Y;
    localparam int unsigned M2  = (M1 > L) ? M1 : L;
    localparam int unsigned MAX = (M2 > 128) ? M2 : 128;
    localparam int unsigned CW  = $clog2(((MAX > START_CYC) ? MAX : START_CYC) + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, START, WAIT} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [K-1:0]    key_sh_q, key_sh_d;
    logic [127:0]    nonce_sh_q, nonce_sh_d;
    logic [L-1:0]    ad_sh_q, ad_sh_d;
    logic [Y-1:0]    ct_sh_q, ct_sh_d;
    logic [2:0]      key_so_q, key_so_d, nonce_so_q, nonce_so_d;
    logic [2:0]      ad_so_q, ad_so_d, ct_so_q, ct_so_d;
    logic [6:0]      r64_q, r64_d;
    logic            r128_q, r128_d, rpt_q, rpt_d;
    logic            start_q, start_d, done_q, done_d;
    logic            busy_q, busy_d, load_ready_q, load_ready_d;
    logic [16:0]     rnd;

`ifdef ASCON_LOADER_LFSR_EN
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    logic [31:0] lfsr_q, lfsr_d;

    // Free-running across transactions; only reset restores the seed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= SEED;
        else      lfsr_q <= lfsr_d;
    end
`else
    logic unused_seed;
    always_comb unused_seed = ^SEED;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_sh_d     = key_sh_q;
        nonce_sh_d   = nonce_sh_q;
        ad_sh_d      = ad_sh_q;
        ct_sh_d      = ct_sh_q;
        key_so_d     = '0;
        nonce_so_d   = '0;
        ad_so_d      = '0;
        ct_so_d      = '0;
        r64_d        = '0;
        r128_d       = 1'b0;
        rpt_d        = 1'b0;
        start_d      = 1'b0;
        done_d       = 1'b0;
        load_ready_d = 1'b0;
        rnd          = '0;
`ifdef ASCON_LOADER_LFSR_EN
        lfsr_d       = lfsr_q;
`endif
        case (state_q)
            IDLE: begin
                load_ready_d = 1'b1;
                if (load_valid && load_ready_q) begin
                    key_sh_d     = key_in;
                    nonce_sh_d   = nonce_in;
                    ad_sh_d      = ad_in;
                    ct_sh_d      = ct_in;
                    cnt_d        = '0;
                    state_d      = SHIFT;
                    load_ready_d = 1'b0;
                end
            end
            SHIFT: begin
`ifdef ASCON_LOADER_LFSR_EN
                lfsr_d = {1'b0, lfsr_q[31:1]} ^ ({32{lfsr_q[0]}} & LFSR_TAPS);
                rnd    = lfsr_d[16:0];
`endif
                {r128_d, rpt_d, r64_d} = rnd[16:8];
                // Shadows shift in zeros, so shorter operands pad with 0 after their MSBs.
                key_so_d   = {rnd[7:6], key_sh_q[K-1]};
                ad_so_d    = {rnd[5:4], ad_sh_q[L-1]};
                ct_so_d    = {rnd[3:2], ct_sh_q[Y-1]};
                nonce_so_d = {rnd[1:0], nonce_sh_q[127]};
                key_sh_d   = key_sh_q << 1;
                nonce_sh_d = nonce_sh_q << 1;
                ad_sh_d    = ad_sh_q << 1;
                ct_sh_d    = ct_sh_q << 1;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == CW'(MAX - 1)) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                start_d = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(START_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (decryption_readyxSI) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            key_sh_q     <= '0;
            nonce_sh_q   <= '0;
            ad_sh_q      <= '0;
            ct_sh_q      <= '0;
            key_so_q     <= '0;
            nonce_so_q   <= '0;
            ad_so_q      <= '0;
            ct_so_q      <= '0;
            r64_q        <= '0;
            r128_q       <= 1'b0;
            rpt_q        <= 1'b0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_sh_q     <= key_sh_d;
            nonce_sh_q   <= nonce_sh_d;
            ad_sh_q      <= ad_sh_d;
            ct_sh_q      <= ct_sh_d;
            key_so_q     <= key_so_d;
            nonce_so_q   <= nonce_so_d;
            ad_so_q      <= ad_so_d;
            ct_so_q      <= ct_so_d;
            r64_q        <= r64_d;
            r128_q       <= r128_d;
            rpt_q        <= rpt_d;
            start_q      <= start_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign keyxSO              = key_so_q;
    assign noncexSO            = nonce_so_q;
    assign associated_dataxSO  = ad_so_q;
    assign cipher_textxSO      = ct_so_q;
    assign r_64xSO             = r64_q;
    assign r_128xSO            = r128_q;
    assign r_ptxSO             = rpt_q;
    assign decryption_startxSO = start_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign load_ready          = load_ready_q;

endmodule

// File: tb/tb_ascon_serial_loader.sv
// Directed bench for ascon_serial_loader: serial order, start/ready timing,
// busy rejection, asynchronous abort and the random slice (with or without LFSR).
module tb_ascon_serial_loader;

    localparam int unsigned K         = 128;
    localparam int unsigned L         = 40;
    localparam int unsigned Y         = 80;
    localparam int unsigned START_CYC = 3;
    localparam logic [31:0] SEED      = 32'hACE1_2468;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [K-1:0]  key_in = '0;
    logic [127:0]  nonce_in = '0;
    logic [L-1:0]  ad_in = '0;
    logic [Y-1:0]  ct_in = '0;
    logic [2:0]    keyxSO, noncexSO, associated_dataxSO, cipher_textxSO;
    logic [6:0]    r_64xSO;
    logic          r_128xSO, r_ptxSO, decryption_startxSO;
    logic          decryption_readyxSI = 1'b0;
    logic          busy, done;

    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;
    logic [31:0]   lfsr_m;

    ascon_serial_loader #(.K(K), .L(L), .Y(Y), .START_CYC(START_CYC), .SEED(SEED)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready),
        .key_in(key_in), .nonce_in(nonce_in), .ad_in(ad_in), .ct_in(ct_in),
        .keyxSO(keyxSO), .noncexSO(noncexSO),
        .associated_dataxSO(associated_dataxSO), .cipher_textxSO(cipher_textxSO),
        .r_64xSO(r_64xSO), .r_128xSO(r_128xSO), .r_ptxSO(r_ptxSO),
        .decryption_startxSO(decryption_startxSO),
        .decryption_readyxSI(decryption_readyxSI),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic logic [23:0] all_outs();
        return {keyxSO, noncexSO, associated_dataxSO, cipher_textxSO, r_64xSO,
                r_128xSO, r_ptxSO, decryption_startxSO, busy, done};
    endfunction

    function automatic logic [16:0] rnd_slice();
        return {r_128xSO, r_ptxSO, r_64xSO, keyxSO[2:1], associated_dataxSO[2:1],
                cipher_textxSO[2:1], noncexSO[2:1]};
    endfunction

    function automatic logic [16:0] exp_rnd();
`ifdef ASCON_LOADER_LFSR_EN
        lfsr_m = lfsr_step(lfsr_m);
        return lfsr_m[16:0];
`else
        return '0;
`endif
    endfunction

    // Drives operands during the current cycle; returns at the cycle-0 sample point.
    task automatic load_op(input logic [127:0] k, input logic [127:0] n,
                           input logic [L-1:0] a, input logic [Y-1:0] c);
        int unsigned w = 0;
        while (load_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (w == 20) check_eq("load_ready_wait", load_ready, 1);
        key_in = k; nonce_in = n; ad_in = a; ct_in = c;
        load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic shift_phase(input int unsigned ncyc, input int unsigned inj, input bit first,
                               output logic [127:0] kr, output logic [127:0] nr,
                               output logic [127:0] ar, output logic [127:0] cr,
                               output int unsigned rerr, output int unsigned serr);
        logic [16:0] e;
        logic [31:0] s1;
        kr = '0; nr = '0; ar = '0; cr = '0; rerr = 0; serr = 0;
        for (int unsigned c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            if (inj != 0 && c == inj + 1) begin
                load_valid = 1'b0;
                decryption_readyxSI = 1'b0;
            end
            kr = {kr[126:0], keyxSO[0]};
            nr = {nr[126:0], noncexSO[0]};
            ar = {ar[126:0], associated_dataxSO[0]};
            cr = {cr[126:0], cipher_textxSO[0]};
            e = exp_rnd();
            if (rnd_slice() !== e) rerr++;
            if (first && c == 1) begin
                s1 = lfsr_step(SEED);
`ifdef ASCON_LOADER_LFSR_EN
                check_eq("rnd_cycle1", rnd_slice(), s1[16:0]);
`else
                check_eq("rnd_cycle1", rnd_slice(), 0);
`endif
            end
            if (busy !== 1'b1 || load_ready !== 1'b0 || decryption_startxSO !== 1'b0 || done !== 1'b0)
                serr++;
            if (inj != 0 && c == inj) begin
                key_in = ~key_in;
                load_valid = 1'b1;
                decryption_readyxSI = 1'b1;
            end
        end
    endtask

    task automatic finish_txn();
        for (int unsigned c = 129; c <= 141; c++) begin
            @(posedge clk); #1;
            if (c >= 129 && c <= 131) check_eq($sformatf("start_c%0d", c), decryption_startxSO, 1);
            if (c == 129) check_eq("start_outs_zero", {rnd_slice(), keyxSO[0], noncexSO[0],
                                   associated_dataxSO[0], cipher_textxSO[0]}, 0);
            if (c == 132) check_eq("start_c132", decryption_startxSO, 0);
            if (c == 139) begin
                check_eq("done_c139", done, 0);
                decryption_readyxSI = 1'b1;
            end
            if (c == 140) begin
                decryption_readyxSI = 1'b0;
                check_eq("done_c140", done, 1);
                check_eq("load_ready_c140", load_ready, 0);
                check_eq("busy_c140", busy, 0);
            end
            if (c == 141) begin
                check_eq("done_c141", done, 0);
                check_eq("load_ready_c141", load_ready, 1);
                check_eq("busy_c141", busy, 0);
            end
        end
    endtask

    task automatic check_streams(input string tag, input logic [127:0] kr, input logic [127:0] nr,
                                 input logic [127:0] ar, input logic [127:0] cr,
                                 input logic [127:0] k, input logic [127:0] n,
                                 input logic [L-1:0] a, input logic [Y-1:0] c,
                                 input int unsigned rerr, input int unsigned serr);
        check_eq({tag, "_key"}, kr, k);
        check_eq({tag, "_nonce"}, nr, n);
        check_eq({tag, "_ad"}, ar, {a, 88'b0});
        check_eq({tag, "_ct"}, cr, {c, 48'b0});
        check_eq({tag, "_rnd_err"}, rerr, 0);
        check_eq({tag, "_status_err"}, serr, 0);
    endtask

    initial begin
        logic [127:0] k1, n1, k2, n2, kr, nr, ar, cr;
        logic [L-1:0] a1, a2;
        logic [Y-1:0] c1, c2;
        int unsigned  rerr, serr;
        k1 = 128'h2db083053e848cefa30007336c47a5a1;
        n1 = 128'h3f3607dbce3503ba84f5843d623de056;
        a1 = 40'h4153434f4e;
        c1 = 80'h87a59a2ea49b233259e3;
        k2 = 128'h0123456789abcdeffedcba9876543210;
        n2 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
        a2 = 40'hc3a5_5a3c_81;
        c2 = 80'h8000_0000_0000_0000_0001;

        // Reset with random inputs
        key_in = {$urandom, $urandom, $urandom, $urandom};
        nonce_in = {$urandom, $urandom, $urandom, $urandom};
        ad_in = L'({$urandom, $urandom});
        ct_in = Y'({$urandom, $urandom, $urandom});
        load_valid = 1'b1;
        decryption_readyxSI = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", all_outs(), 0);
        check_eq("reset_load_ready", load_ready, 1);
        load_valid = 1'b0;
        decryption_readyxSI = 1'b0;
        rst = 1'b1;
        lfsr_m = SEED;
        @(posedge clk); #1;

        // Serial order, start and ready timing
        load_op(k1, n1, a1, c1);
        shift_phase(128, 0, 1'b1, kr, nr, ar, cr, rerr, serr);
        check_streams("txn1", kr, nr, ar, cr, k1, n1, a1, c1, rerr, serr);
        finish_txn();

        // Busy rejection: load_valid and ready pulsed mid-shift are ignored
        load_op(k1, n1, a1, c1);
        shift_phase(128, 10, 1'b0, kr, nr, ar, cr, rerr, serr);
        check_streams("busyrej", kr, nr, ar, cr, k1, n1, a1, c1, rerr, serr);
        finish_txn();

        // Asynchronous abort at cycle 60
        load_op(k2, n2, a2, c2);
        shift_phase(60, 0, 1'b0, kr, nr, ar, cr, rerr, serr);
        check_eq("abort_partial_key", kr[59:0], k2[127:68]);
        #2;
        rst = 1'b0;
        #1;
        check_eq("abort_outs", all_outs(), 0);
        check_eq("abort_load_ready", load_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        lfsr_m = SEED;
        @(posedge clk); #1;
        load_op(k2, n2, a2, c2);
        shift_phase(128, 0, 1'b1, kr, nr, ar, cr, rerr, serr);
        check_streams("restart", kr, nr, ar, cr, k2, n2, a2, c2, rerr, serr);
        finish_txn();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
